// File: rtl/imm_decode_stage.sv
// Registered RV32/RV64 immediate/rd decode stage with a 2-entry valid/ready output buffer.
// Optional macro IMM_DECODE_ILLEGAL_EN: flag unrecognised opcodes as illegal (fmt=7).
module imm_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
`ifdef IMM_DECODE_ILLEGAL_EN
  localparam logic [2:0] FmtIll = 3'd7;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  // Async assert, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Combinational decode of the incoming word.
  logic [31:0] w;
  logic [31:0] imm32;
  entry_t      dec;

  assign w = instruction_word;

  always_comb begin
    imm32       = '0;
    dec.rd      = w[11:7];
    dec.fmt     = FmtR;
    dec.illegal = 1'b0;
    case (w[6:0])
      OpLui, OpAuipc: begin
        dec.fmt = FmtU;
        imm32   = {w[31:12], 12'b0};
      end
      OpJal: begin
        dec.fmt = FmtJ;
        imm32   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      OpJalr, OpLoad, OpImm: begin
        dec.fmt = FmtI;
        imm32   = {{20{w[31]}}, w[31:20]};
      end
      OpStore: begin
        dec.fmt = FmtS;
        dec.rd  = 5'd0;
        imm32   = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      OpBranch: begin
        dec.fmt = FmtB;
        dec.rd  = 5'd0;
        imm32   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      OpReg: dec.fmt = FmtR;
      default: begin
`ifdef IMM_DECODE_ILLEGAL_EN
        dec.fmt     = FmtIll;
        dec.rd      = 5'd0;
        dec.illegal = 1'b1;
`else
        dec.fmt     = FmtR;
`endif
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // Output buffer: head_q is always presented, tail_q holds the second entry.
  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  logic   push, pop;

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = StEmpty;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign imm     = head_q.imm;
  assign rd      = head_q.rd;
  assign fmt     = head_q.fmt;
  assign illegal = head_q.illegal;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised, registered immediate/destination decode stage for the RV32/RV64 front end. It accepts one 32-bit instruction word per cycle over a valid/ready handshake and classifies it as R/I/S/B/U/J. It outputs the sign-extended XLEN-bit immediate, rd and format code through a 2-entry output buffer. It sits between fetch and the register-read stage and generalises the U-type-only decoder to every base-ISA format with flow control.

## Interface
- XLEN, 32, datapath width of imm; legal values 32, 64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept this cycle
- instruction_word  in  32  raw instruction
- out_valid  out  1  decoded entry present
- out_ready  in  1  consumer takes entry this cycle
- imm  out  XLEN  sign-extended immediate
- rd  out  5  destination register (0 for S/B)
- fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
- illegal  out  1  opcode not recognised (see Configuration)

## Operation
- Opcode map (bits 6:0):
  - 0110111/0010111 → U
  - 1101111 → J
  - 1100111/0000011/0010011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110011 → R
  - anything else → illegal
- Immediates, then sign-extended from bit 31 to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25],inst[11:7]}
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
  - U = {inst[31:12],12'b0}
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}
  - R and illegal: imm=0
- rd = inst[11:7] for R/I/U/J; 0 for S/B/illegal.
- Buffer FSM: EMPTY, ONE, TWO; strict FIFO order.
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - EMPTY: push → ONE.
  - ONE: push&&!pop → TWO; pop&&!push → EMPTY; push&&pop → ONE, head replaced by the new entry.
  - TWO: pop → ONE; no push possible.
- in_ready = (state != TWO); out_valid = (state != EMPTY). Both derive from state only; no combinational path from out_ready to in_ready.
- Outputs always show the head entry and hold stable while out_valid && !out_ready.
- flush: next state EMPTY; a push in the same cycle is dropped; flush has priority over push/pop.

## Timing
- Reset (async assert, sync release inside the block):
  - state=EMPTY; in_ready=1; out_valid=0
  - imm=0, rd=0, fmt=0, illegal=0; storage cleared
- Latency: instruction accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 per cycle with out_ready held high. No bubble in ONE with simultaneous push and pop.
- Backpressure: at most 2 entries buffered; in_ready drops the cycle after the second unpopped accept.
- Reset asserted mid-transfer: all entries lost, outputs immediately return to reset values; no partial entry emerges after release.
- in_valid && !in_ready: input ignored; the producer must hold the word.

## Configuration
- IMM_DECODE_ILLEGAL_EN defined:
  - Unrecognised opcodes give fmt=7, illegal=1, imm=0, rd=0.
  - Entry still flows through the buffer like any other.
- IMM_DECODE_ILLEGAL_EN undefined:
  - illegal is tied to 0.
  - Unrecognised opcodes decode as R: fmt=0, imm=0, rd=inst[11:7].
  - Opcode-check logic is not synthesised.

## Test plan
- LUI, XLEN=32: 0x123452B7 with out_ready=1 → one cycle later out_valid=1, imm=0x12345000, rd=5, fmt=4.
- XLEN=64, 0xFFFFF2B7 → imm=0xFFFFFFFFFFFFF000, rd=5, fmt=4.
- BEQ x0,x0,-4: 0xFE000EE3 → imm=0xFFFFFFFC, rd=0, fmt=3; JAL 0x0080006F → imm=8, rd=0, fmt=5.
- Backpressure: out_ready=0, push three words on consecutive cycles → first two accepted, in_ready=0 on the third, which is held. Raise out_ready → all three emerge in order, one per cycle.
- 0x0000007F with macro defined → fmt=7, illegal=1, imm=0. Without the macro → fmt=0, illegal=0, rd=0.
- Buffer in TWO: pulse flush → next cycle out_valid=0, in_ready=1. Repeat, but drop rst_n mid-stream → outputs zero asynchronously and nothing stale appears after release.
